// File: rtl/dsp_simd_pkg.sv
// Shared widths and the result record for the SIMD DSP result collector.
package dsp_simd_pkg;
  localparam int LANE_A_W = 10;
  localparam int LANE_B_W = 9;
  localparam int LANE_Z_W = 19;
  localparam int PROD_W   = 16;

  typedef struct packed {
    logic [1:0]          err;
    logic [2*PROD_W-1:0] data;
  } result_t;
endpackage

// File: rtl/dsp_simd_result_fifo.sv
// Synchronous result FIFO with occupancy count; pointers carry an extra wrap bit.
module dsp_simd_result_fifo
  import dsp_simd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  result_t wdata,
  input  logic    pop,
  output result_t rdata,
  output logic [AW:0] count,
  output logic    empty
);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  result_t     mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, do_pop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count  = wptr - rptr;
  assign do_pop = pop && !empty;
  assign rdata  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) rptr <= rptr + PTR_ONE;
    end
  end

  // The upstream credit check must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/dsp_simd_result_collector.sv
// Issue/collect wrapper for two DSP lanes in SIMD unsigned 8x8 multiply mode.
// Tracks issued pairs through the DSP latency and queues products behind a credit check.
module dsp_simd_result_collector
  import dsp_simd_pkg::*;
#(
  parameter int DSP_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [7:0]          op_a0_i,
  input  logic [7:0]          op_b0_i,
  input  logic [7:0]          op_a1_i,
  input  logic [7:0]          op_b1_i,
  output logic [LANE_A_W-1:0] dsp_a0_o,
  output logic [LANE_B_W-1:0] dsp_b0_o,
  output logic [LANE_A_W-1:0] dsp_a1_o,
  output logic [LANE_B_W-1:0] dsp_b1_o,
  input  logic [LANE_Z_W-1:0] dsp_z0_i,
  input  logic [LANE_Z_W-1:0] dsp_z1_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [2*PROD_W-1:0] res_data_o,
  output logic [1:0]          res_err_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DSP_LATENCY-1:0] vpipe;
  logic [CW-1:0]          count, inflight;
  logic [CW:0]            credit_used;
  logic                   fire, capture, empty;
  result_t                wr_res, rd_res;

  assign dsp_a0_o = {{(LANE_A_W-8){1'b0}}, op_a0_i};
  assign dsp_b0_o = {{(LANE_B_W-8){1'b0}}, op_b0_i};
  assign dsp_a1_o = {{(LANE_A_W-8){1'b0}}, op_a1_i};
  assign dsp_b1_o = {{(LANE_B_W-8){1'b0}}, op_b1_i};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DSP_LATENCY; i++) inflight = inflight + CW'(vpipe[i]);
  end

  // Credits count both queued and in-flight results, so a capture never meets a full FIFO.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign op_ready_o  = credit_used < (CW+1)'(FIFO_DEPTH);
  assign fire        = op_valid_i && op_ready_o;
  assign capture     = vpipe[DSP_LATENCY-1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) vpipe <= '0;
    else            vpipe <= DSP_LATENCY'({vpipe, fire});
  end

  assign wr_res.err  = {|dsp_z1_i[LANE_Z_W-1:PROD_W], |dsp_z0_i[LANE_Z_W-1:PROD_W]};
  assign wr_res.data = {dsp_z1_i[PROD_W-1:0], dsp_z0_i[PROD_W-1:0]};

  dsp_simd_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .push  (capture),
    .wdata (wr_res),
    .pop   (res_ready_i),
    .rdata (rd_res),
    .count (count),
    .empty (empty)
  );

  assign res_valid_o = !empty;
  assign res_data_o  = rd_res.data;
  assign res_err_o   = rd_res.err;
endmodule
